// File: rtl/tsc_sync_ctl.sv
// tsc_sync_ctl: qualifies the GPS 1PPS, arms a TSC realignment, then tracks the
// phase error reported by the TSC PLL and forces a resync when it persists.
module tsc_sync_ctl #(
   parameter int unsigned PERIOD      = 200000000,
   parameter int unsigned TOL         = 1000,
   parameter int unsigned QUAL_CNT    = 3,
   parameter int unsigned PDIFF_LIMIT = 100,
   parameter int unsigned ERR_CNT     = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        gps_1pps,
   input  logic        gps_3dfix_d,
   input  logic        pll_trig,
   input  logic [31:0] pdiff_1pps,
   output logic        tsc_sync,
   output logic        pfd_resync,
   output logic        locked,
   output logic [2:0]  sync_state,
   output logic [15:0] resync_cnt
);

   localparam logic [2:0]  IDLE     = 3'd0;
   localparam logic [2:0]  QUALIFY  = 3'd1;
   localparam logic [2:0]  ARM      = 3'd2;
   localparam logic [2:0]  TRACK    = 3'd3;
   localparam logic [2:0]  HOLDOVER = 3'd4;

   localparam logic [31:0] WIN_LO    = 32'(PERIOD - TOL);
   localparam logic [31:0] WIN_HI    = 32'(PERIOD + TOL);
   localparam logic [31:0] TMO_VAL   = 32'(PERIOD + TOL + 1);
   localparam logic [15:0] QUAL_MAX  = 16'(QUAL_CNT);
   localparam logic [15:0] ERR_MAX   = 16'(ERR_CNT);
   localparam logic [32:0] PDIFF_MAX = 33'(PDIFF_LIMIT);

   logic        run;
   logic [31:0] ivl_cnt;
   logic        pps_seen;
   logic [15:0] good_cnt;
   logic [15:0] good_nxt;
   logic [15:0] err_cnt;
   logic [15:0] err_nxt;
   logic [15:0] resync_nxt;
   logic [2:0]  state_nxt;
   logic        trk_entry;
   logic        trk_entry_nxt;
   logic        pulse_good;
   logic        timeout;
   logic [32:0] pdiff_ext;
   logic [32:0] pdiff_mag;
   logic        phase_err;

   // Keep everything frozen for one edge after reset release
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) run <= 1'b0;
      else        run <= 1'b1;
   end

   // Interval counter since the last pulse, and "a pulse was seen since IDLE" flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ivl_cnt  <= '0;
         pps_seen <= 1'b0;
      end else if (run) begin
         if (gps_1pps)            ivl_cnt <= 32'd1;
         else if (ivl_cnt != '1)  ivl_cnt <= ivl_cnt + 32'd1;
         pps_seen <= (sync_state != IDLE) && (pps_seen || gps_1pps);
      end
   end

   // Pulse classification, timeout and 33-bit phase-error magnitude
   always_comb begin
      pulse_good = pps_seen && (ivl_cnt >= WIN_LO) && (ivl_cnt <= WIN_HI);
      timeout    = !gps_1pps && (ivl_cnt == TMO_VAL);
      pdiff_ext  = {pdiff_1pps[31], pdiff_1pps};
      pdiff_mag  = pdiff_1pps[31] ? (~pdiff_ext + 33'd1) : pdiff_ext;
      phase_err  = pdiff_mag > PDIFF_MAX;
   end

   // Next-state and counter update; loss of fix overrides everything
   always_comb begin
      state_nxt     = sync_state;
      good_nxt      = good_cnt;
      err_nxt       = err_cnt;
      resync_nxt    = resync_cnt;
      trk_entry_nxt = 1'b0;
      if (!gps_3dfix_d) begin
         state_nxt = IDLE;
         good_nxt  = '0;
         err_nxt   = '0;
      end else begin
         case (sync_state)
            IDLE: begin
               state_nxt = QUALIFY;
               good_nxt  = '0;
               err_nxt   = '0;
            end
            QUALIFY: begin
               if (gps_1pps) begin
                  if (!pulse_good) begin
                     good_nxt = '0;
                  end else if (good_cnt + 16'd1 >= QUAL_MAX) begin
                     state_nxt = ARM;
                     good_nxt  = '0;
                  end else begin
                     good_nxt = good_cnt + 16'd1;
                  end
               end else if (timeout) begin
                  good_nxt = '0;
               end
            end
            ARM: begin
               if (gps_1pps) begin
                  state_nxt     = TRACK;
                  err_nxt       = '0;
                  trk_entry_nxt = 1'b1;
               end else if (timeout) begin
                  state_nxt = QUALIFY;
                  good_nxt  = '0;
               end
            end
            TRACK: begin
               if (timeout) begin
                  state_nxt = HOLDOVER;
                  err_nxt   = '0;
               end else if (pll_trig) begin
                  if (!phase_err) begin
                     err_nxt = '0;
                  end else if (err_cnt + 16'd1 >= ERR_MAX) begin
                     state_nxt = ARM;
                     err_nxt   = '0;
                     if (resync_cnt != 16'hFFFF) resync_nxt = resync_cnt + 16'd1;
                  end else begin
                     err_nxt = err_cnt + 16'd1;
                  end
               end
            end
            HOLDOVER: begin
               if (gps_1pps) begin
                  if (pulse_good) begin
                     state_nxt = TRACK;
                     err_nxt   = '0;
                  end else begin
                     state_nxt = QUALIFY;
                     good_nxt  = '0;
                  end
               end
            end
            default: begin
               state_nxt = IDLE;
               good_nxt  = '0;
               err_nxt   = '0;
            end
         endcase
      end
   end

   // State, counters and registered outputs derived from the next state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_state <= IDLE;
         good_cnt   <= '0;
         err_cnt    <= '0;
         resync_cnt <= '0;
         trk_entry  <= 1'b0;
         tsc_sync   <= 1'b0;
         locked     <= 1'b0;
         pfd_resync <= 1'b0;
      end else if (run) begin
         sync_state <= state_nxt;
         good_cnt   <= good_nxt;
         err_cnt    <= err_nxt;
         resync_cnt <= resync_nxt;
         trk_entry  <= trk_entry_nxt;
         tsc_sync   <= (state_nxt == ARM);
         locked     <= (state_nxt == TRACK);
         pfd_resync <= trk_entry;
      end
   end

endmodule

// File: tb/tb_tsc_sync_ctl.sv
// tb_tsc_sync_ctl: directed scenarios with randomized jitter and phase values,
// checked every cycle against a timestamp-based behavioural model.
module tb_tsc_sync_ctl;

   localparam int PERIOD      = 1000;
   localparam int TOL         = 10;
   localparam int QUAL_CNT    = 3;
   localparam int PDIFF_LIMIT = 100;
   localparam int ERR_CNT     = 4;

   localparam int S_IDLE  = 0;
   localparam int S_QUAL  = 1;
   localparam int S_ARM   = 2;
   localparam int S_TRACK = 3;
   localparam int S_HOLD  = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        gps_1pps;
   logic        gps_3dfix_d;
   logic        pll_trig;
   logic [31:0] pdiff_1pps;
   logic        tsc_sync;
   logic        pfd_resync;
   logic        locked;
   logic [2:0]  sync_state;
   logic [15:0] resync_cnt;

   int n_assert = 0;
   int n_fail   = 0;

   // model: edge index since reset release, edge of last sampled pulse, edge of ARM->TRACK
   int edge_no;
   int last_pps;
   int trk_edge;
   bit m_seen;
   int m_state;
   int m_good;
   int m_err;
   int m_resync;

   tsc_sync_ctl #(
      .PERIOD(PERIOD), .TOL(TOL), .QUAL_CNT(QUAL_CNT),
      .PDIFF_LIMIT(PDIFF_LIMIT), .ERR_CNT(ERR_CNT)
   ) dut (
      .clk(clk), .rst_n(rst_n), .gps_1pps(gps_1pps), .gps_3dfix_d(gps_3dfix_d),
      .pll_trig(pll_trig), .pdiff_1pps(pdiff_1pps), .tsc_sync(tsc_sync),
      .pfd_resync(pfd_resync), .locked(locked), .sync_state(sync_state),
      .resync_cnt(resync_cnt)
   );

   // 100 MHz-style bench clock
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      edge_no  = 0;
      last_pps = 2;   // counter reads 0 on the first active edge
      trk_edge = -10;
      m_seen   = 1'b0;
      m_state  = S_IDLE;
      m_good   = 0;
      m_err    = 0;
      m_resync = 0;
   endtask

   // Predict the effect of the coming clock edge from the current inputs
   task automatic model_edge();
      int     since;
      bit     good;
      bit     tmo;
      int     prior;
      longint p;
      longint mag;
      edge_no++;
      if (edge_no < 2) return;
      since = edge_no - last_pps;
      good  = m_seen && (since >= PERIOD - TOL) && (since <= PERIOD + TOL);
      tmo   = !gps_1pps && (since == PERIOD + TOL + 1);
      prior = m_state;
      if (!gps_3dfix_d) begin
         m_state = S_IDLE;
         m_good  = 0;
         m_err   = 0;
      end else begin
         case (prior)
            S_IDLE: begin
               m_state = S_QUAL;
               m_good  = 0;
            end
            S_QUAL: begin
               if (gps_1pps) begin
                  m_good = good ? m_good + 1 : 0;
                  if (m_good == QUAL_CNT) begin
                     m_state = S_ARM;
                     m_good  = 0;
                  end
               end else if (tmo) begin
                  m_good = 0;
               end
            end
            S_ARM: begin
               if (gps_1pps) m_state = S_TRACK;
               else if (tmo) begin
                  m_state = S_QUAL;
                  m_good  = 0;
               end
            end
            S_TRACK: begin
               if (tmo) begin
                  m_state = S_HOLD;
                  m_err   = 0;
               end else if (pll_trig) begin
                  p   = longint'($signed(pdiff_1pps));
                  mag = (p < 0) ? -p : p;
                  m_err = (mag > longint'(PDIFF_LIMIT)) ? m_err + 1 : 0;
                  if (m_err == ERR_CNT) begin
                     m_state = S_ARM;
                     m_err   = 0;
                     if (m_resync < 65535) m_resync++;
                  end
               end
            end
            default: begin
               if (gps_1pps) begin
                  m_state = good ? S_TRACK : S_QUAL;
                  m_good  = 0;
               end
            end
         endcase
      end
      m_seen = (prior != S_IDLE) && (m_seen || gps_1pps);
      if (gps_1pps) last_pps = edge_no;
      if (prior == S_ARM && m_state == S_TRACK) trk_edge = edge_no;
   endtask

   task automatic step();
      logic [21:0] exp_v;
      logic [21:0] obs_v;
      model_edge();
      @(posedge clk);
      #1;
      gps_1pps = 1'b0;
      pll_trig = 1'b0;
      exp_v = {3'(m_state), (m_state == S_ARM), (edge_no == trk_edge + 1),
               (m_state == S_TRACK), 16'(m_resync)};
      obs_v = {sync_state, tsc_sync, pfd_resync, locked, resync_cnt};
      check("cycle", 32'(obs_v), 32'(exp_v));
   endtask

   // Pulse on the edge where the interval since the last pulse equals g
   task automatic pulse_at(input int g);
      while (edge_no + 1 - last_pps < g) step();
      gps_1pps = 1'b1;
      step();
   endtask

   task automatic trig(input int pd);
      pdiff_1pps = 32'(pd);
      pll_trig   = 1'b1;
      step();
      step();
   endtask

   function automatic int good_gap();
      return PERIOD - TOL + int'($urandom_range(0, 2 * TOL));
   endfunction

   task automatic check_all_zero(input string tag);
      check({tag, "_state"},  32'(sync_state), 32'(S_IDLE));
      check({tag, "_tsc"},    32'(tsc_sync),   32'd0);
      check({tag, "_pfd"},    32'(pfd_resync), 32'd0);
      check({tag, "_locked"}, 32'(locked),     32'd0);
      check({tag, "_resync"}, 32'(resync_cnt), 32'd0);
   endtask

   initial begin
      rst_n = 1'b0; gps_1pps = 1'b0; gps_3dfix_d = 1'b1; pll_trig = 1'b0; pdiff_1pps = '0;
      model_reset();
      #2;
      check_all_zero("reset");
      @(posedge clk); #1;
      rst_n = 1'b1;
      step();
      check("first_edge_idle", 32'(sync_state), 32'(S_IDLE));
      step();
      check("qualify_entry", 32'(sync_state), 32'(S_QUAL));

      // bring-up: first pulse bad, three good pulses arm, the fifth tracks
      pulse_at(5);
      pulse_at(1000);
      pulse_at(1000);
      check("qual_two_good", 32'(sync_state), 32'(S_QUAL));
      pulse_at(1000);
      check("arm_state", 32'(sync_state), 32'(S_ARM));
      check("arm_tsc", 32'(tsc_sync), 32'd1);
      pulse_at(1000);
      check("track_state", 32'(sync_state), 32'(S_TRACK));
      check("track_tsc_low", 32'(tsc_sync), 32'd0);
      check("track_locked", 32'(locked), 32'd1);
      check("pfd_not_yet", 32'(pfd_resync), 32'd0);
      step();
      check("pfd_pulse", 32'(pfd_resync), 32'd1);
      step();
      check("pfd_single", 32'(pfd_resync), 32'd0);

      // tracking with jittered pulses and in-limit phase reports
      pulse_at(1005);
      check("track_1005", 32'(sync_state), 32'(S_TRACK));
      for (int i = 0; i < 3; i++) begin
         repeat ($urandom_range(5, 900)) step();
         trig(int'($urandom_range(0, 2 * PDIFF_LIMIT)) - PDIFF_LIMIT);
         pulse_at(good_gap());
      end
      check("track_jitter", 32'(sync_state), 32'(S_TRACK));

      // phase errors: a 100 clears the run, four in a row resync
      pulse_at(1000);
      trig(150); trig(-150); trig(int'(32'h8000_0000)); trig(100);
      check("pdiff_100_stays", 32'(sync_state), 32'(S_TRACK));
      check("no_resync_yet", 32'(resync_cnt), 32'd0);
      trig(150); trig(-150); trig(int'(32'h8000_0000)); trig(101);
      check("resync_arm", 32'(sync_state), 32'(S_ARM));
      check("resync_cnt_1", 32'(resync_cnt), 32'd1);
      check("resync_tsc", 32'(tsc_sync), 32'd1);
      trig(5000);
      pulse_at(1000);
      check("rearm_track", 32'(sync_state), 32'(S_TRACK));

      // timeout into holdover, then a late pulse drops to qualify
      while (edge_no + 1 - last_pps <= PERIOD + TOL) step();
      check("track_at_1010", 32'(sync_state), 32'(S_TRACK));
      step();
      check("holdover_state", 32'(sync_state), 32'(S_HOLD));
      check("holdover_locked", 32'(locked), 32'd0);
      check("holdover_tsc", 32'(tsc_sync), 32'd0);
      pulse_at(1500);
      check("holdover_bad", 32'(sync_state), 32'(S_QUAL));

      // out-of-window spacing restarts qualification
      pulse_at(1000);
      pulse_at(1000);
      pulse_at(1020);
      check("qual_after_1020", 32'(sync_state), 32'(S_QUAL));
      pulse_at(good_gap());
      pulse_at(good_gap());
      check("qual_two_more", 32'(sync_state), 32'(S_QUAL));
      pulse_at(good_gap());
      check("qual_rearm", 32'(sync_state), 32'(S_ARM));

      // timeout while armed, phase reports ignored outside tracking
      trig(-7000);
      while (edge_no + 1 - last_pps <= PERIOD + TOL + 1) step();
      check("arm_timeout", 32'(sync_state), 32'(S_QUAL));
      check("arm_timeout_tsc", 32'(tsc_sync), 32'd0);

      // loss of fix while armed
      pulse_at(1500);
      pulse_at(1000);
      pulse_at(1000);
      pulse_at(1000);
      check("arm_again", 32'(sync_state), 32'(S_ARM));
      gps_3dfix_d = 1'b0;
      step();
      check("fix_drop_idle", 32'(sync_state), 32'(S_IDLE));
      check("fix_drop_tsc", 32'(tsc_sync), 32'd0);
      gps_3dfix_d = 1'b1;
      step();
      check("fix_back_qual", 32'(sync_state), 32'(S_QUAL));

      // window edges: 990/1010 good, 989 bad, first pulse after IDLE bad
      pulse_at(1000);
      check("first_after_idle", 32'(sync_state), 32'(S_QUAL));
      pulse_at(990);
      pulse_at(1010);
      pulse_at(989);
      pulse_at(990);
      pulse_at(1010);
      check("window_edges_qual", 32'(sync_state), 32'(S_QUAL));
      pulse_at(1000);
      check("window_edges_arm", 32'(sync_state), 32'(S_ARM));

      // asynchronous reset while armed
      step();
      #2;
      rst_n = 1'b0;
      #1;
      check_all_zero("arm_reset");
      @(posedge clk); #1;
      rst_n = 1'b1;
      model_reset();
      step();
      check("rerelease_idle", 32'(sync_state), 32'(S_IDLE));
      step();
      pulse_at(5);
      pulse_at(good_gap());
      pulse_at(good_gap());
      pulse_at(good_gap());
      pulse_at(good_gap());
      check("relock_track", 32'(sync_state), 32'(S_TRACK));

      // resync counter saturation
      force dut.resync_cnt = 16'hFFFF;
      m_resync = 65535;
      step();
      step();
      release dut.resync_cnt;
      step();
      check("resync_preset", 32'(resync_cnt), 32'h0000_FFFF);
      trig(150); trig(150); trig(-150); trig(-300);
      check("sat_arm", 32'(sync_state), 32'(S_ARM));
      check("sat_hold", 32'(resync_cnt), 32'h0000_FFFF);
      pulse_at(1000);
      step();
      check("sat_track", 32'(locked), 32'd1);

      // asynchronous reset while tracking
      #2;
      rst_n = 1'b0;
      #1;
      check_all_zero("track_reset");

      #20;
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/tsc_sync_ctl.md
TSC_SYNC_CTL -- requirements
Module: tsc_sync_ctl

Interface
REQ-001 SHALL have parameter PERIOD, default 200000000, nominal clk cycles per GPS second.
REQ-002 SHALL have parameter TOL, default 1000, allowed interval deviation in cycles, applied as +/-.
REQ-003 SHALL have parameter QUAL_CNT, default 3, consecutive good pulses needed to qualify.
REQ-004 SHALL have parameter PDIFF_LIMIT, default 100, magnitude of phase error in cycles that counts as an error.
REQ-005 SHALL have parameter ERR_CNT, default 4, consecutive phase errors that force a resync.
REQ-006 SHALL have ports:
  - clk  in  1  system clock, 200 MHz; the block has one clock.
  - rst_n  in  1  reset, asynchronous and active-low.
  - gps_1pps  in  1  single-cycle GPS pulse, already synchronous to clk.
  - gps_3dfix_d  in  1  GPS 3D fix valid, level.
  - pll_trig  in  1  single-cycle strobe from tsc; pdiff_1pps is valid in that cycle.
  - pdiff_1pps  in  32  signed phase difference between gps and tsc pps, in cycles.
  - tsc_sync  out  1  level to tsc; when high, tsc realigns to the next gps_1pps.
  - pfd_resync  out  1  single-cycle pulse; clears the PFD/PLL loop state.
  - locked  out  1  high while in TRACK.
  - sync_state  out  3  current state encoding.
  - resync_cnt  out  16  number of resyncs, saturating.

Function
REQ-007 SHALL keep a 32-bit interval counter that clears to 1 in the cycle after each gps_1pps, otherwise increments, and saturates at 0xFFFFFFFF.
REQ-008 SHALL classify a gps_1pps as good when the counter value in that cycle lies in [PERIOD-TOL, PERIOD+TOL] inclusive, otherwise bad; the first pulse after IDLE is always bad.
REQ-009 SHALL assert an internal timeout when the counter reaches PERIOD+TOL+1 with no gps_1pps, once per interval.
REQ-010 SHALL implement states with these encodings: IDLE=0, QUALIFY=1, ARM=2, TRACK=3, HOLDOVER=4.
REQ-011 SHALL go from any state to IDLE in the next cycle when gps_3dfix_d=0; this has priority over all other transitions.
REQ-012 SHALL go IDLE -> QUALIFY when gps_3dfix_d=1, with the good-pulse counter cleared.
REQ-013 SHALL in QUALIFY: good pulse increments the good count; bad pulse or timeout clears it; reaching QUAL_CNT goes to ARM.
REQ-014 SHALL in ARM: drive tsc_sync=1 registered; on the next gps_1pps, go to TRACK and deassert tsc_sync in the following cycle.
REQ-015 SHALL in ARM: timeout goes to QUALIFY with tsc_sync=0.
REQ-016 SHALL pulse pfd_resync for exactly one cycle, 1 cycle after the ARM->TRACK transition.
REQ-017 SHALL in TRACK, on pll_trig: |pdiff_1pps| > PDIFF_LIMIT increments the error count, otherwise clears it; reaching ERR_CNT goes to ARM and increments resync_cnt.
REQ-018 SHALL compute |pdiff_1pps| in 33 bits so 0x80000000 gives magnitude 2^31, not a negative value.
REQ-019 SHALL in TRACK go to HOLDOVER on timeout, clearing the error count.
REQ-020 SHALL in HOLDOVER: a good pulse returns to TRACK; a bad pulse goes to QUALIFY; keep tsc_sync=0 and locked=0.
REQ-021 SHALL let a timeout and a gps_1pps in the same cycle act as the pulse only.
REQ-022 SHALL ignore pll_trig outside TRACK.
REQ-023 SHALL hold resync_cnt at 0xFFFF once reached.
REQ-024 SHALL register all outputs; sync_state reflects the current state with 0 added latency.

Reset
REQ-025 SHALL on rst_n=0 asynchronously set state IDLE, tsc_sync=0, pfd_resync=0, locked=0, sync_state=0, resync_cnt=0, all counters 0.
REQ-026 SHALL on reset mid-ARM drop tsc_sync immediately, without waiting for a clk edge.
REQ-027 SHALL leave reset synchronously; the first state change occurs no earlier than the second clk edge after rst_n rises.

Verification (PERIOD=1000, TOL=10, QUAL_CNT=3, PDIFF_LIMIT=100, ERR_CNT=4)
REQ-028 SHALL cover: fix=1, pulses every 1000 cycles -> QUALIFY after 1 cycle; ARM after 4th pulse; tsc_sync high until 5th pulse; pfd_resync 1 cycle; locked=1.
REQ-029 SHALL cover: in QUALIFY, pulse spacing 1000, 1000, 1020 -> good count clears, ARM only after 3 further good pulses.
REQ-030 SHALL cover: in TRACK, 4 pll_trig with pdiff=+150, -150, 0x80000000, +101 -> ARM, resync_cnt=1; pdiff=100 with 3 errors -> stays TRACK.
REQ-031 SHALL cover: in TRACK, no pulse for 1011 cycles -> HOLDOVER, locked=0; pulse at 1005 -> TRACK; pulse at 1500 -> QUALIFY.
REQ-032 SHALL cover: fix drops during ARM -> IDLE next cycle, tsc_sync=0; rst_n low mid-TRACK -> all outputs 0 asynchronously.
REQ-033 SHALL cover: force resync_cnt to 0xFFFF, then trigger a resync -> resync_cnt stays 0xFFFF.
